rv32_register_file: RTL and testbench
=====================================

# rv32_register_file

RV32I integer register file for the core's decode/execute stage: 32 registers of 32 bits, one write port and two independent read ports. Register x0 always reads as zero. Reads are registered with one-cycle latency, and an optional write-to-read bypass is available. The block sits between instruction decode (which supplies the rs1/rs2/rd indices) and the writeback stage.

## Interface
- DATA_WIDTH, 32, register width in bits.
- INDEX_WIDTH, 5, index width; depth is 2**INDEX_WIDTH (32).
- clk  input  1  clock; every state change occurs on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising clk edge.
- wr_en  input  1  write enable.
- wr_index  input  INDEX_WIDTH  destination register index (rd).
- wr_data  input  DATA_WIDTH  write data.
- rd_en1  input  1  read enable, port 1.
- rd_index1  input  INDEX_WIDTH  source index, port 1 (rs1).
- rd_en2  input  1  read enable, port 2.
- rd_index2  input  INDEX_WIDTH  source index, port 2 (rs2).
- rd_data1  output  DATA_WIDTH  registered read data, port 1.
- rd_data2  output  DATA_WIDTH  registered read data, port 2.

## Operation
- Reset:
  - All 32 registers clear to 0.
  - rd_data1 and rd_data2 clear to 0.
  - Reset has priority over any write or read in the same cycle.
- Write:
  - On a rising edge with wr_en=1 and reset=0, regs[wr_index] <= wr_data.
  - A write to index 0 is discarded; x0 stays 0.
- Read, per port n:
  - On a rising edge with rd_en_n=1, rd_data_n <= regs[rd_index_n].
  - When rd_index_n=0, rd_data_n <= 0.
  - With rd_en_n=0, rd_data_n holds its previous value.
- The two read ports are fully independent.
  - Both may read the same index in the same cycle.
  - Both may read the write target in the same cycle.
- No handshake; every enabled access completes in one cycle.
- Widths are exact; no extension or truncation.

## Timing
- Write latency: 1 edge. The new value is readable by a read enabled on the next edge.
- Read latency: 1 edge. rd_data_n is valid after the edge on which rd_en_n was sampled high.
- Simultaneous write and read of the same nonzero index on one edge:
  - With the bypass compiled in: rd_data_n = wr_data.
  - Without the bypass: rd_data_n = the old register content.
- Reset asserted mid-operation takes effect on the next edge.
  - Pending writes are lost.
  - Outputs read 0 on the cycle after reset.
- Index values wrap naturally modulo 32; there are no out-of-range indices.

## Configuration
- REGFILE_BYPASS_EN
  - Defined: a same-edge write and read to an equal nonzero index forward wr_data into rd_data_n (write-first behaviour).
  - Undefined: no forwarding; the read returns the pre-write value (read-first behaviour).
  - x0 returns 0 in both builds.

## Test plan
- Reset, then read all indices with both ports enabled -> rd_data1 = rd_data2 = 0 for every index.
- Write wr_data = index to indices 0..31 on consecutive edges, then sweep both read ports over 0..31 -> rd_data = index for 1..31; index 0 returns 0.
- Write 0xFF to x1, read x1 on the next edge -> rd_data1 = 0x000000FF.
- Same-edge write of 0xDEADBEEF to x5 while reading x5 (x5 previously holds 5) -> rd_data = 0xDEADBEEF with REGFILE_BYPASS_EN; 0x00000005 without it.
- Read x3 with rd_en1=1, then drop rd_en1 and change rd_index1 to 7 -> rd_data1 holds x3's value.
- Write 0x1234 to x9, assert reset for one edge, then read x9 -> 0.

Source files
------------

// File: rtl/rv32_register_file.sv
// rv32_register_file: RV32I integer register file, 32 x 32-bit, one write port and
// two independent registered read ports. x0 is hardwired to zero.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a same-edge write and read of an
// equal nonzero index forwards wr_data to the read port (write-first). When undefined,
// the read returns the pre-write register content (read-first).
module rv32_register_file #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_en1,
  input  logic [INDEX_WIDTH-1:0] rd_index1,
  input  logic                   rd_en2,
  input  logic [INDEX_WIDTH-1:0] rd_index2,
  output logic [DATA_WIDTH-1:0]  rd_data1,
  output logic [DATA_WIDTH-1:0]  rd_data2
);

  localparam int unsigned Depth = 2 ** INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [DATA_WIDTH-1:0] regs_d [Depth];
  logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
  logic                  wr_active;

  // A write only takes effect for a nonzero destination; x0 writes are dropped.
  assign wr_active = wr_en && (wr_index != '0);

  // Next-state for the register array.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_active) begin
      regs_d[wr_index] = wr_data;
    end
    regs_d[0] = '0;
  end

  // Next-state for both read ports; a disabled port holds its last value.
  always_comb begin
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;

    if (rd_en1) begin
      if (rd_index1 == '0) begin
        rd_data1_d = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_active && (wr_index == rd_index1)) begin
        rd_data1_d = wr_data;
`endif
      end else begin
        rd_data1_d = regs_q[rd_index1];
      end
    end

    if (rd_en2) begin
      if (rd_index2 == '0) begin
        rd_data2_d = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_active && (wr_index == rd_index2)) begin
        rd_data2_d = wr_data;
`endif
      end else begin
        rd_data2_d = regs_q[rd_index2];
      end
    end
  end

  // State update; synchronous reset wins over any write or read on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      rd_data1_q <= '0;
      rd_data2_q <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;

endmodule

// File: tb/tb_rv32_register_file.sv
// Directed self-checking bench for rv32_register_file. Expected values for the same-edge
// write/read case follow the build option REGFILE_BYPASS_EN.
module tb_rv32_register_file;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_index;
  logic [31:0] wr_data;
  logic        rd_en1;
  logic [4:0]  rd_index1;
  logic        rd_en2;
  logic [4:0]  rd_index2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;

  int unsigned n_compared;
  int unsigned n_mismatched;

  rv32_register_file #(
    .DATA_WIDTH (32),
    .INDEX_WIDTH(5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_data  (wr_data),
    .rd_en1   (rd_en1),
    .rd_index1(rd_index1),
    .rd_en2   (rd_en2),
    .rd_index2(rd_index2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en     = 1'b0;
    wr_index  = '0;
    wr_data   = '0;
    rd_en1    = 1'b0;
    rd_index1 = '0;
    rd_en2    = 1'b0;
    rd_index2 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_compared++;
    if (rd_data1 !== 32'h0) begin
      n_mismatched++;
      $display("FAIL reset_rd1: got %h expected %h", rd_data1, 32'h0);
    end
    n_compared++;
    if (rd_data2 !== 32'h0) begin
      n_mismatched++;
      $display("FAIL reset_rd2: got %h expected %h", rd_data2, 32'h0);
    end
    rd_en1 = 1'b1;
    rd_en2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_index1 = 5'(i);
      rd_index2 = 5'(31 - i);
      tick();
      n_compared++;
      if (rd_data1 !== 32'h0) begin
        n_mismatched++;
        $display("FAIL reset_sweep_rd1[%0d]: got %h expected %h", i, rd_data1, 32'h0);
      end
      n_compared++;
      if (rd_data2 !== 32'h0) begin
        n_mismatched++;
        $display("FAIL reset_sweep_rd2[%0d]: got %h expected %h", 31 - i, rd_data2, 32'h0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_sweep();
    logic [31:0] exp;
    idle_inputs();
    wr_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wr_index = 5'(i);
      wr_data  = 32'(i);
      tick();
    end
    wr_en  = 1'b0;
    rd_en1 = 1'b1;
    rd_en2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_index1 = 5'(i);
      rd_index2 = 5'(i);
      tick();
      exp = (i == 0) ? 32'h0 : 32'(i);
      n_compared++;
      if (rd_data1 !== exp) begin
        n_mismatched++;
        $display("FAIL sweep_rd1[%0d]: got %h expected %h", i, rd_data1, exp);
      end
      n_compared++;
      if (rd_data2 !== exp) begin
        n_mismatched++;
        $display("FAIL sweep_rd2[%0d]: got %h expected %h", i, rd_data2, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_then_read();
    idle_inputs();
    wr_en    = 1'b1;
    wr_index = 5'd1;
    wr_data  = 32'h0000_00FF;
    tick();
    wr_en     = 1'b0;
    rd_en1    = 1'b1;
    rd_index1 = 5'd1;
    tick();
    n_compared++;
    if (rd_data1 !== 32'h0000_00FF) begin
      n_mismatched++;
      $display("FAIL write_read_x1: got %h expected %h", rd_data1, 32'h0000_00FF);
    end
    idle_inputs();
  endtask

  task automatic test_same_edge();
    logic [31:0] exp;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hDEAD_BEEF;
`else
    exp = 32'h0000_0005;
`endif
    idle_inputs();
    wr_en     = 1'b1;
    wr_index  = 5'd5;
    wr_data   = 32'hDEAD_BEEF;
    rd_en1    = 1'b1;
    rd_index1 = 5'd5;
    rd_en2    = 1'b1;
    rd_index2 = 5'd5;
    tick();
    n_compared++;
    if (rd_data1 !== exp) begin
      n_mismatched++;
      $display("FAIL same_edge_rd1: got %h expected %h", rd_data1, exp);
    end
    n_compared++;
    if (rd_data2 !== exp) begin
      n_mismatched++;
      $display("FAIL same_edge_rd2: got %h expected %h", rd_data2, exp);
    end
    // Write landed regardless of build.
    wr_en = 1'b0;
    tick();
    n_compared++;
    if (rd_data1 !== 32'hDEAD_BEEF) begin
      n_mismatched++;
      $display("FAIL same_edge_after: got %h expected %h", rd_data1, 32'hDEAD_BEEF);
    end
    // x0 stays zero even with a simultaneous write and read.
    wr_en     = 1'b1;
    wr_index  = 5'd0;
    wr_data   = 32'hFFFF_FFFF;
    rd_index1 = 5'd0;
    rd_index2 = 5'd0;
    tick();
    n_compared++;
    if (rd_data1 !== 32'h0) begin
      n_mismatched++;
      $display("FAIL x0_same_edge_rd1: got %h expected %h", rd_data1, 32'h0);
    end
    wr_en = 1'b0;
    tick();
    n_compared++;
    if (rd_data2 !== 32'h0) begin
      n_mismatched++;
      $display("FAIL x0_after_rd2: got %h expected %h", rd_data2, 32'h0);
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    idle_inputs();
    rd_en1    = 1'b1;
    rd_index1 = 5'd3;
    tick();
    n_compared++;
    if (rd_data1 !== 32'h3) begin
      n_mismatched++;
      $display("FAIL hold_first: got %h expected %h", rd_data1, 32'h3);
    end
    rd_en1    = 1'b0;
    rd_index1 = 5'd7;
    rd_en2    = 1'b1;
    rd_index2 = 5'd7;
    tick();
    n_compared++;
    if (rd_data1 !== 32'h3) begin
      n_mismatched++;
      $display("FAIL hold_rd1: got %h expected %h", rd_data1, 32'h3);
    end
    n_compared++;
    if (rd_data2 !== 32'h7) begin
      n_mismatched++;
      $display("FAIL independent_rd2: got %h expected %h", rd_data2, 32'h7);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    wr_en    = 1'b1;
    wr_index = 5'd12;
    wr_data  = 32'hA5A5_0012;
    tick();
    // Read x12 on the very next edge while writing x13.
    wr_index  = 5'd13;
    wr_data   = 32'h5A5A_0013;
    rd_en1    = 1'b1;
    rd_index1 = 5'd12;
    rd_en2    = 1'b1;
    rd_index2 = 5'd31;
    tick();
    n_compared++;
    if (rd_data1 !== 32'hA5A5_0012) begin
      n_mismatched++;
      $display("FAIL b2b_rd1: got %h expected %h", rd_data1, 32'hA5A5_0012);
    end
    n_compared++;
    if (rd_data2 !== 32'h0000_001F) begin
      n_mismatched++;
      $display("FAIL b2b_rd2: got %h expected %h", rd_data2, 32'h0000_001F);
    end
    wr_en     = 1'b0;
    rd_index1 = 5'd13;
    rd_index2 = 5'd12;
    tick();
    n_compared++;
    if (rd_data1 !== 32'h5A5A_0013) begin
      n_mismatched++;
      $display("FAIL b2b_x13: got %h expected %h", rd_data1, 32'h5A5A_0013);
    end
    n_compared++;
    if (rd_data2 !== 32'hA5A5_0012) begin
      n_mismatched++;
      $display("FAIL b2b_x12_rd2: got %h expected %h", rd_data2, 32'hA5A5_0012);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    wr_en    = 1'b1;
    wr_index = 5'd9;
    wr_data  = 32'h0000_1234;
    tick();
    // Reset with a pending write and active reads on the same edge.
    reset     = 1'b1;
    wr_index  = 5'd10;
    wr_data   = 32'h0000_AAAA;
    rd_en1    = 1'b1;
    rd_index1 = 5'd9;
    rd_en2    = 1'b1;
    rd_index2 = 5'd31;
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    n_compared++;
    if (rd_data1 !== 32'h0) begin
      n_mismatched++;
      $display("FAIL midreset_rd1: got %h expected %h", rd_data1, 32'h0);
    end
    n_compared++;
    if (rd_data2 !== 32'h0) begin
      n_mismatched++;
      $display("FAIL midreset_rd2: got %h expected %h", rd_data2, 32'h0);
    end
    rd_index1 = 5'd9;
    rd_index2 = 5'd10;
    tick();
    n_compared++;
    if (rd_data1 !== 32'h0) begin
      n_mismatched++;
      $display("FAIL midreset_x9: got %h expected %h", rd_data1, 32'h0);
    end
    n_compared++;
    if (rd_data2 !== 32'h0) begin
      n_mismatched++;
      $display("FAIL midreset_x10: got %h expected %h", rd_data2, 32'h0);
    end
    idle_inputs();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    idle_inputs();
    test_reset();
    test_write_sweep();
    test_write_then_read();
    test_same_edge();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
